rx_packet_fifo: RTL and testbench
=================================

RX_PACKET_FIFO -- requirements
Module: rx_packet_fifo

Interface
REQ-001 The parameter list SHALL include DEPTH_LOG2, default 9, log2 of the buffer depth in 37-bit words ({tlast, tkeep[3:0], tdata[31:0]}).
REQ-002 The ports SHALL be s00_axis_aclk, input, 1 bit: the single clock, driven from the MAC Rx AXIS clock (m00_axis_aclk of eth_10g).
REQ-003 The ports SHALL include s00_axis_aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The ports SHALL include s00_axis_tdata/tkeep/tvalid/tlast/tuser, inputs, 32/4/1/1/1 bits: MAC Rx stream with no tready; tuser=1 on the tlast beat marks a bad frame.
REQ-005 The ports SHALL include m00_axis_tdata/tkeep/tvalid/tlast, outputs, 32/4/1/1 bits, and m00_axis_tready, input, 1 bit: the filtered output stream.
REQ-006 The ports SHALL include o_drop_bad, o_drop_ovf, outputs, 16 bits each: drop counters (see Configuration).

Function
REQ-007 Store-and-forward: no word of a frame SHALL appear on m00 before that frame's tlast beat has been written and committed.
REQ-008 The write side SHALL use the states ACCEPT and DISCARD; the reset state is ACCEPT.
REQ-009 In ACCEPT, each tvalid beat SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo 2^DEPTH_LOG2.
REQ-010 A tlast beat with tuser=0 SHALL commit the frame: commit_ptr <= wr_ptr+1 in the same cycle as the write.
REQ-011 A tlast beat with tuser=1 SHALL rewind wr_ptr to commit_ptr; the frame SHALL be dropped and the state SHALL stay ACCEPT.
REQ-012 Full SHALL mean (wr_ptr - rd_ptr) == 2^DEPTH_LOG2, computed with one extra pointer bit.
REQ-013 A beat arriving while full and not tlast SHALL rewind wr_ptr to commit_ptr, drop the frame and enter DISCARD.
REQ-014 A beat arriving while full with tlast=1 SHALL rewind wr_ptr to commit_ptr, drop the frame and stay in ACCEPT.
REQ-015 In DISCARD, beats SHALL be ignored; a tlast beat SHALL return the state to ACCEPT with nothing written.
REQ-016 Frames longer than 2^DEPTH_LOG2 words SHALL always be dropped as overflow.
REQ-017 Committed data SHALL never be overwritten or lost.
REQ-018 The read side SHALL present data when rd_ptr != commit_ptr, through a registered output stage (skid/output register).
REQ-019 m00_axis_tvalid SHALL assert no later than 2 cycles after the commit cycle.
REQ-020 Once m00_axis_tvalid is asserted, m00 data, keep and last SHALL hold stable until the cycle in which tready=1.
REQ-021 With tready held high, the read side SHALL sustain 1 word/cycle.
REQ-022 Simultaneous write, commit and read SHALL all take effect in the same cycle, and a commit SHALL not stall the read.
REQ-023 Output tkeep and tlast SHALL equal the input values stored for the same word.
REQ-024 Drop and commit SHALL be decided only on the beat carrying tlast or on the overflowing beat; no other beat SHALL cause a drop or commit.

Reset
REQ-025 Asserting s00_axis_aresetn low SHALL asynchronously clear wr_ptr, commit_ptr, rd_ptr, the output register and both counters.
REQ-026 Asserting reset SHALL force m00_axis_tvalid=0, m00_axis_tdata=0, tkeep=0, tlast=0 and the state to ACCEPT.
REQ-027 Reset asserted mid-frame SHALL lose all buffered and partial frames.
REQ-028 If deassertion occurs mid-frame, the remainder of that frame SHALL be accepted as a new frame; upstream is responsible for framing after reset.
REQ-029 Deassertion SHALL be synchronised inside the block, and the first beat SHALL be accepted on the second clock edge after release.

Configuration
REQ-030 Macro RX_PACKET_FIFO_STATS_EN, when defined, SHALL make o_drop_bad count frames dropped per REQ-011 and o_drop_ovf count frames dropped per REQ-013/014.
REQ-031 With RX_PACKET_FIFO_STATS_EN defined, both counters SHALL saturate at 16'hFFFF and SHALL update one cycle after the dropping beat.
REQ-032 Without RX_PACKET_FIFO_STATS_EN, o_drop_bad and o_drop_ovf SHALL be constant 0, with no counter logic synthesised.

Verification
REQ-033 Scenario: one 16-beat good frame, tready=1 -> 16 identical beats out, tlast on beat 16, tvalid within 2 cycles of the input tlast.
REQ-034 Scenario: a 10-beat frame with tuser=1 on tlast, then an 8-beat good frame -> only the 8-beat frame is output; o_drop_bad=1 (STATS_EN).
REQ-035 Scenario: DEPTH_LOG2=4, tready=0, a 12-beat good frame then a 10-beat frame -> second frame dropped, DISCARD until its tlast; after tready=1, exactly 12 beats out; o_drop_ovf=1.
REQ-036 Scenario: a 20-beat frame with DEPTH_LOG2=4 -> nothing output, o_drop_ovf=1, and a following 4-beat frame passes intact.
REQ-037 Scenario: random tready (50%) over 200 back-to-back good frames of 1-64 beats -> output equals input exactly, with no tvalid drop while unaccepted.
REQ-038 Scenario: reset asserted on beat 5 of a 9-beat frame with 2 committed frames queued -> m00_axis_tvalid=0 immediately, and nothing from either frame appears after release.

Source files
------------

// File: rtl/rx_packet_fifo.sv
// rtl/rx_packet_fifo.sv - store-and-forward Rx packet FIFO that drops bad and overflowing frames
// Optional drop counters: define RX_PACKET_FIFO_STATS_EN.
module rx_packet_fifo #(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_aresetn,
    input  logic [31:0] s00_axis_tdata,
    input  logic [3:0]  s00_axis_tkeep,
    input  logic        s00_axis_tvalid,
    input  logic        s00_axis_tlast,
    input  logic        s00_axis_tuser,
    output logic [31:0] m00_axis_tdata,
    output logic [3:0]  m00_axis_tkeep,
    output logic        m00_axis_tvalid,
    output logic        m00_axis_tlast,
    input  logic        m00_axis_tready,
    output logic [15:0] o_drop_bad,
    output logic [15:0] o_drop_ovf
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } wr_state_e;

    // Single-stage release sync so the first beat lands on the second edge after release.
    logic rst_sync_q;
    logic rst_n;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    assign rst_n = rst_sync_q;

    wr_state_e       state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            m_valid_q, m_valid_d;
    logic [36:0]     m_word_q, m_word_d;
    logic [36:0]     mem_q [DEPTH];
    logic [36:0]     rd_word;
    logic            mem_we;
    logic            full;
    logic            avail;
    logic            load;
    logic            drop_bad;
    logic            drop_ovf;

    assign full    = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign rd_word = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge s00_axis_aclk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        drop_bad     = 1'b0;
        drop_ovf     = 1'b0;
        if (s00_axis_tvalid) begin
            case (state_q)
                ST_ACCEPT: begin
                    if (full) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_ovf = 1'b1;
                        if (!s00_axis_tlast) begin
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        mem_we = 1'b1;
                        if (s00_axis_tlast && s00_axis_tuser) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_bad = 1'b1;
                        end else if (s00_axis_tlast) begin
                            wr_ptr_d     = wr_ptr_q + PW'(1);
                            commit_ptr_d = wr_ptr_q + PW'(1);
                        end else begin
                            wr_ptr_d = wr_ptr_q + PW'(1);
                        end
                    end
                end
                ST_DISCARD: begin
                    if (s00_axis_tlast) begin
                        state_d = ST_ACCEPT;
                    end
                end
                default: state_d = ST_ACCEPT;
            endcase
        end
    end

    // Output register refills whenever it is empty or being drained, giving 1 word/cycle.
    always_comb begin
        avail     = rd_ptr_q != commit_ptr_q;
        load      = avail && (!m_valid_q || m00_axis_tready);
        rd_ptr_d  = rd_ptr_q;
        m_valid_d = m_valid_q;
        m_word_d  = m_word_q;
        if (load) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            m_valid_d = 1'b1;
            m_word_d  = rd_word;
        end else if (m00_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            m_valid_q    <= 1'b0;
            m_word_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            m_valid_q    <= m_valid_d;
            m_word_q     <= m_word_d;
        end
    end

    assign m00_axis_tvalid = m_valid_q;
    assign m00_axis_tdata  = m_word_q[31:0];
    assign m00_axis_tkeep  = m_word_q[35:32];
    assign m00_axis_tlast  = m_word_q[36];

`ifdef RX_PACKET_FIFO_STATS_EN
    logic [15:0] drop_bad_q;
    logic [15:0] drop_ovf_q;

    always_ff @(posedge s00_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            drop_bad_q <= '0;
            drop_ovf_q <= '0;
        end else begin
            if (drop_bad && (drop_bad_q != 16'hFFFF)) begin
                drop_bad_q <= drop_bad_q + 16'd1;
            end
            if (drop_ovf && (drop_ovf_q != 16'hFFFF)) begin
                drop_ovf_q <= drop_ovf_q + 16'd1;
            end
        end
    end

    assign o_drop_bad = drop_bad_q;
    assign o_drop_ovf = drop_ovf_q;
`else
    logic unused_drops;

    assign unused_drops = drop_bad ^ drop_ovf;
    assign o_drop_bad   = '0;
    assign o_drop_ovf   = '0;
`endif

endmodule

// File: tb/tb_rx_packet_fifo.sv
// tb/tb_rx_packet_fifo.sv - randomized self-checking bench for rx_packet_fifo with a frame-level queue model
module tb_rx_packet_fifo;

    localparam int DL2 = 6;
    localparam int D   = 1 << DL2;

`ifdef RX_PACKET_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tuser;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b0;
    logic [15:0] drop_bad;
    logic [15:0] drop_ovf;

    int          checks  = 0;
    int          errors  = 0;
    logic [36:0] exp_q[$];
    int          pushed  = 0;
    int          rcv     = 0;
    int          exp_bad = 0;
    int          exp_ovf = 0;
    int          rdy_mode = 1;
    logic        stalled = 1'b0;
    logic [36:0] held = '0;

    always #5 clk = ~clk;

    rx_packet_fifo #(.DEPTH_LOG2(DL2)) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tkeep   (s_tkeep),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tuser   (s_tuser),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tkeep   (m_tkeep),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tready  (m_tready),
        .o_drop_bad       (drop_bad),
        .o_drop_ovf       (drop_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink: choose tready for the coming edge and score the word that edge will accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled  = 1'b0;
            m_tready = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_word", {m_tlast, m_tkeep, m_tdata}, held);
            end
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            if (m_tvalid && m_tready) begin
                rcv++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_tvalid, 0);
                end else begin
                    check("word", {m_tlast, m_tkeep, m_tdata}, exp_q.pop_front());
                end
            end
            stalled = m_tvalid && !m_tready;
            held    = {m_tlast, m_tkeep, m_tdata};
        end
    end

    task automatic send_frame(input int len, input bit bad, input bit ovf);
        logic [36:0] words[$];
        logic [36:0] w;
        for (int i = 0; i < len; i++) begin
            w[31:0]  = $urandom;
            w[35:32] = 4'($urandom_range(0, 15));
            w[36]    = (i == len - 1);
            s_tdata  = w[31:0];
            s_tkeep  = w[35:32];
            s_tlast  = w[36];
            s_tuser  = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
            s_tvalid = 1'b1;
            words.push_back(w);
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        if (ovf) begin
            exp_ovf++;
        end else if (bad) begin
            exp_bad++;
        end else begin
            foreach (words[k]) exp_q.push_back(words[k]);
            pushed += len;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int rcv0;
        int len;
        int n;
        bit bad;

        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tkeep", m_tkeep, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_drop_bad", drop_bad, 0);
        check("rst_drop_ovf", drop_ovf, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        rdy_mode = 1;
        send_frame(16, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("commit_latency", m_tvalid, 1);
        drain("drain_good16");

        send_frame(10, 1'b1, 1'b0);
        send_frame(8, 1'b0, 1'b0);
        drain("drain_bad_then_good");
        check("drop_bad_1", drop_bad, STATS ? exp_bad : 0);

        rdy_mode = 0;
        rcv0 = rcv;
        send_frame(D * 3 / 4, 1'b0, 1'b0);
        send_frame(D * 5 / 8, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("drop_ovf_1", drop_ovf, STATS ? exp_ovf : 0);
        rdy_mode = 1;
        drain("drain_ovf_full");
        check("ovf_full_count", rcv - rcv0, D * 3 / 4);

        send_frame(D + 4, 1'b0, 1'b1);
        send_frame(4, 1'b0, 1'b0);
        drain("drain_long_frame");
        check("drop_ovf_2", drop_ovf, STATS ? exp_ovf : 0);

        rdy_mode = 2;
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 64);
            bad = ($urandom_range(0, 7) == 0);
            n = 0;
            while ((pushed - rcv + len > D) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check("space_wait", n >= 5000, 0);
            send_frame(len, bad, 1'b0);
        end
        drain("drain_random");
        check("drop_bad_random", drop_bad, STATS ? exp_bad : 0);
        check("drop_ovf_random", drop_ovf, STATS ? exp_ovf : 0);

        rdy_mode = 0;
        send_frame(5, 1'b0, 1'b0);
        send_frame(7, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s_tdata  = $urandom;
            s_tkeep  = 4'hF;
            s_tlast  = 1'b0;
            s_tvalid = 1'b1;
            @(negedge clk);
        end
        s_tdata = $urandom;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_tdata", m_tdata, 0);
        check("midrst_tkeep", m_tkeep, 0);
        check("midrst_tlast", m_tlast, 0);
        s_tvalid = 1'b0;
        exp_q.delete();
        pushed  = rcv;
        exp_bad = 0;
        exp_ovf = 0;
        repeat (2) @(negedge clk);
        check("midrst_drop_bad", drop_bad, 0);
        check("midrst_drop_ovf", drop_ovf, 0);
        rst_n    = 1'b1;
        s_tdata  = 32'hDEADBEEF;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b1;
        s_tuser  = 1'b0;
        s_tvalid = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        send_frame(6, 1'b0, 1'b0);
        rdy_mode = 1;
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
